// File: rtl/fxp_mac_pipe.sv
// Fixed-point MAC pipeline: capture, multiply, round, then a
// saturating accumulate with sticky overflow and a MAC counter.
module fxp_mac_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int GUARD = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       wrAddr,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf,
  output logic [CNT_W-1:0] mac_count
);

  localparam int ACC_W = WIDTH + GUARD;
  localparam int PW    = 2 * WIDTH;
  localparam int RW    = PW - FRAC;
  localparam int SW    = ((RW > ACC_W) ? RW : ACC_W) + 1;

  localparam logic signed [PW-1:0] HALF =
    PW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] AMAX =
    SW'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] AMIN = ~AMAX;
  localparam logic signed [ACC_W-1:0] RMAX =
    ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] RMIN = ~RMAX;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_MAC = 2'd1,
    OP_CLR = 2'd2,
    OP_MUL = 2'd3
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    op_e           op;
    logic [PW-1:0] prod;
  } s2_t;

  typedef struct packed {
    op_e           op;
    logic [RW-1:0] rp;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  op_e dec_op;

  always_comb begin
    dec_op = OP_NOP;
    unique case (1'b1)
      (wrAddr == 4'd1): dec_op = OP_MAC;
      (wrAddr == 4'd2): dec_op = OP_CLR;
      (wrAddr == 4'd3): dec_op = OP_MUL;
      default:          dec_op = OP_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
    end else begin
      s1.op <= dec_op;
      s1.a  <= A;
      s1.b  <= B;
    end
  end

  logic signed [PW-1:0] prod_c;

  assign prod_c = PW'($signed(s1.a)) * PW'($signed(s1.b));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2 <= '0;
    end else begin
      s2.op   <= s1.op;
      s2.prod <= prod_c;
    end
  end

  // Round half up in Q.2FRAC before dropping FRAC bits.
  logic signed [PW-1:0] rsum_c;
  logic [RW-1:0]        rp_c;

  assign rsum_c = $signed(s2.prod) + HALF;
  assign rp_c   = RW'(rsum_c >>> FRAC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3 <= '0;
    end else begin
      s3.op <= s2.op;
      s3.rp <= rp_c;
    end
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_n;
  logic signed [SW-1:0]    acc_x;
  logic signed [SW-1:0]    rp_x;
  logic signed [SW-1:0]    sum;
  logic [WIDTH-1:0]        res_n;
  logic                    val_n;
  logic                    ovf_n;
  logic                    sat;
  logic                    clamp;
  logic [CNT_W-1:0]        cnt_n;

  assign acc_x = SW'(acc);
  assign rp_x  = SW'($signed(s3.rp));

  always_comb begin
    acc_n = acc;
    res_n = result;
    val_n = 1'b0;
    ovf_n = ovf;
    cnt_n = mac_count;
    sum   = '0;
    sat   = 1'b0;
    clamp = 1'b0;
    unique case (1'b1)
      (s3.op == OP_MAC),
      (s3.op == OP_MUL): begin
        sum = (s3.op == OP_MAC) ? acc_x + rp_x : rp_x;
        if (sum > AMAX) begin
          sum = AMAX;
          sat = 1'b1;
        end else if (sum < AMIN) begin
          sum = AMIN;
          sat = 1'b1;
        end
        acc_n = ACC_W'(sum);
        // acc keeps its guard range; only the output clamps.
        if (acc_n > RMAX) begin
          res_n = {1'b0, {(WIDTH-1){1'b1}}};
          clamp = 1'b1;
        end else if (acc_n < RMIN) begin
          res_n = {1'b1, {(WIDTH-1){1'b0}}};
          clamp = 1'b1;
        end else begin
          res_n = WIDTH'(acc_n);
        end
        val_n = 1'b1;
        ovf_n = ovf | sat | clamp;
        cnt_n = mac_count + CNT_W'(1);
      end
      (s3.op == OP_CLR): begin
        acc_n = '0;
        res_n = '0;
        val_n = 1'b1;
        ovf_n = 1'b0;
        cnt_n = '0;
      end
      default: begin
        val_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      mac_count    <= '0;
    end else begin
      acc          <= acc_n;
      result       <= res_n;
      result_valid <= val_n;
      ovf          <= ovf_n;
      mac_count    <= cnt_n;
    end
  end

endmodule
